vectorgates_decoder: RTL and testbench
======================================

VECTORGATES_DECODER -- requirements
Module: vectorgates_decoder

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset; ports SHALL be named clk and reset.
REQ-002 Parameters SHALL be, one per line:
- W, 3: width of each recovered operand.
- DEPTH, 2: entries in the output FIFO; power of two, at least 2.
- CNT_W, 8: width of the error counter.

REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_or_bitwise  in  W  transmitted bitwise OR of a and b.
- in_or_logical  in  1  transmitted logical OR of a and b.
- in_not  in  2W  transmitted {~b, ~a}.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_a  out  W  recovered operand a.
- out_b  out  W  recovered operand b.
- out_err  out  1  consistency error for the head entry.
- err_count  out  CNT_W  saturating count of erroneous accepts.
- err_sticky  out  1  at least one error since reset or clear.
- clr_err  in  1  clear err_count and err_sticky.

Function
REQ-004 Input handshake: an accept occurs on a rising clk edge with in_valid=1 and in_ready=1; in_ready SHALL equal (FIFO not full), with no combinational path from out_ready.
REQ-005 Decode SHALL be:
- a = ~in_not[W-1:0]
- b = ~in_not[2W-1:W]
REQ-006 The error flag SHALL be 1 if either check fails:
- in_or_bitwise != (a | b)
- in_or_logical != ((|a) | (|b))
REQ-007 Each accept SHALL write {a, b, err} at the FIFO tail; entries SHALL leave in acceptance order.
REQ-008 Latency SHALL be 1 cycle: a word accepted at edge N into an empty FIFO is visible with out_valid=1 in the cycle after edge N.
- No same-cycle bypass from input to output.
REQ-009 Output handshake: a pop occurs on an edge with out_valid=1 and out_ready=1.
- out_a, out_b and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-010 When out_valid=0, out_a, out_b and out_err SHALL be driven to 0.
REQ-011 FIFO occupancy rules:
- Push and pop on the same edge with the FIFO neither empty nor full SHALL leave occupancy unchanged.
- When full, in_ready=0 and no push SHALL occur, even if a pop occurs on that edge.
- When empty, no pop SHALL occur.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH.
- Occupancy SHALL be tracked so that full and empty are unambiguous when the pointers are equal.
REQ-013 err_count SHALL increment by 1 on each accept whose err=1.
- It SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-014 err_sticky SHALL set on any accept with err=1 and hold until a clear or reset.
REQ-015 clr_err=1 at an edge SHALL zero err_count and err_sticky.
- If an erroneous accept occurs on the same edge, the result SHALL be err_count=1 and err_sticky=1 (clear first, then count).
REQ-016 Error accounting SHALL occur at accept time, independent of when the entry is popped.

Reset
REQ-017 With reset=1 at an edge, the block SHALL set:
- pointers and occupancy to 0
- out_valid=0; out_a, out_b, out_err = 0
- err_count=0, err_sticky=0
- in_ready=1 from the following cycle
REQ-018 Reset SHALL take priority over any simultaneous push, pop or clr_err.
- Stored entries SHALL be discarded.

Verification (W=3, DEPTH=2 unless noted)
REQ-019 Clean decode: in_not=6'b110010, in_or_bitwise=3'b101, in_or_logical=1, out_ready=1 -> next cycle out_valid=1, out_a=3'b101, out_b=3'b001, out_err=0; err_count stays 0.
REQ-020 Mismatch: same word with in_or_bitwise=3'b111 -> out_err=1, err_count=1, err_sticky=1.
REQ-021 Backpressure: out_ready=0, three back-to-back valid words -> in_ready=0 after two accepts, third word held; then out_ready=1 -> all three words emerge in order, one per cycle.
REQ-022 Saturation: CNT_W=2, five consecutive erroneous accepts -> err_count sequence 1,2,3,3,3; err_sticky=1.
REQ-023 Reset mid-operation: two entries stored, err_count=2, reset pulsed one cycle -> out_valid=0, err_count=0, in_ready=1; a following clean word appears with 1-cycle latency.
REQ-024 Clear collision: err_count=3, clr_err=1 on the same edge as an erroneous accept -> err_count=1, err_sticky=1.

Source files
------------

// File: rtl/vectorgates_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vectorgates_decoder
//  Description : Recovers operands a and b from a transmitted word of gate
//                outputs ({~b,~a}, bitwise OR, logical OR).
//                Each recovered pair is cross-checked against the two OR
//                fields. The pair and its error flag are queued in a small
//                output FIFO. A saturating error counter and a sticky flag
//                are updated when a word is accepted.
//  Ports       : clk, reset                  - clock, sync active-high reset
//                in_valid/in_ready           - input handshake
//                in_or_bitwise, in_or_logical, in_not - transmitted word
//                out_valid/out_ready         - output handshake
//                out_a, out_b, out_err       - FIFO head (zero when empty)
//                err_count, err_sticky       - error accounting
//                clr_err                     - clear error accounting
//  Revision    : 1.0 - initial release
// ============================================================================
module vectorgates_decoder #(
  parameter int W     = 3,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_or_bitwise,
  input  logic             in_or_logical,
  input  logic [2*W-1:0]   in_not,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky,
  input  logic             clr_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] c_depth   = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  // --------------------------------------------------------------------------
  // Decode and consistency check
  // --------------------------------------------------------------------------
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_err;

  assign w_a   = ~in_not[W-1:0];
  assign w_b   = ~in_not[2*W-1:W];
  assign w_err = (in_or_bitwise != (w_a | w_b)) ||
                 (in_or_logical != ((|w_a) | (|w_b)));

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  logic [W-1:0]     r_mem_a   [DEPTH];
  logic [W-1:0]     r_mem_b   [DEPTH];
  logic             r_mem_err [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_err_count;
  logic             r_err_sticky;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_occ == c_depth);
  assign w_empty = (r_occ == '0);
  // Ready depends on stored occupancy only, so a pop in the same cycle
  // never frees a slot for the word presented while full.
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_a     = w_empty ? '0   : r_mem_a[r_rd_ptr];
  assign out_b     = w_empty ? '0   : r_mem_b[r_rd_ptr];
  assign out_err   = w_empty ? 1'b0 : r_mem_err[r_rd_ptr];

  // Storage has no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem_a[r_wr_ptr]   <= w_a;
      r_mem_b[r_wr_ptr]   <= w_b;
      r_mem_err[r_wr_ptr] <= w_err;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Error accounting: applied at accept time; a clear on the same edge is
  // applied first so the erroneous accept still counts.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] w_cnt_base;
  logic             w_sticky_base;
  logic             w_err_accept;

  assign w_cnt_base    = clr_err ? '0 : r_err_count;
  assign w_sticky_base = clr_err ? 1'b0 : r_err_sticky;
  assign w_err_accept  = w_push && w_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_count  <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (w_err_accept && (w_cnt_base != c_cnt_max)) begin
        r_err_count <= w_cnt_base + CNT_W'(1);
      end else begin
        r_err_count <= w_cnt_base;
      end
      r_err_sticky <= w_sticky_base || w_err_accept;
    end
  end

  assign err_count  = r_err_count;
  assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_vectorgates_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vectorgates_decoder
//  Description : Self-checking bench for vectorgates_decoder. Two instances
//                share one stimulus stream: default parameters, and CNT_W=2
//                for counter saturation. A queue-based model is compared on
//                every falling edge. Directed literal checks pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vectorgates_decoder;

  localparam int W     = 3;
  localparam int DEPTH = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_or_bitwise;
  logic           in_or_logical;
  logic [2*W-1:0] in_not;
  logic           out_ready;
  logic           clr_err;

  logic           in_ready,  s_in_ready;
  logic           out_valid, s_out_valid;
  logic [W-1:0]   out_a, out_b, s_out_a, s_out_b;
  logic           out_err, s_out_err;
  logic [7:0]     err_count;
  logic [1:0]     s_err_count;
  logic           err_sticky, s_err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vectorgates_decoder #(.W(W), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_or_bitwise(in_or_bitwise), .in_or_logical(in_or_logical),
    .in_not(in_not), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_err(out_err),
    .err_count(err_count), .err_sticky(err_sticky), .clr_err(clr_err)
  );

  vectorgates_decoder #(.W(W), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_or_bitwise(in_or_bitwise), .in_or_logical(in_or_logical),
    .in_not(in_not), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_a(s_out_a), .out_b(s_out_b), .out_err(s_out_err),
    .err_count(s_err_count), .err_sticky(s_err_sticky), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: queue of decoded entries plus plain integer counters.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err;
  } ent_t;

  ent_t q[$];
  int   m_cnt;
  int   m_cnt_sat;
  bit   m_sticky;
  bit   live = 0;

  always @(posedge clk) begin
    ent_t e;
    bit   acc;
    bit   pop;
    if (reset) begin
      q.delete();
      m_cnt     = 0;
      m_cnt_sat = 0;
      m_sticky  = 0;
      live      = 1;
    end else if (live) begin
      e.a   = ~in_not[W-1:0];
      e.b   = ~in_not[2*W-1:W];
      e.err = (in_or_bitwise != (e.a | e.b)) ||
              (in_or_logical != ((e.a != 0) || (e.b != 0)));
      acc = in_valid && (q.size() < DEPTH);
      pop = (q.size() > 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (clr_err) begin
        m_cnt = 0; m_cnt_sat = 0; m_sticky = 0;
      end
      if (acc && e.err) begin
        m_cnt     = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : 3;
        m_sticky  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      if (q.size() > 0) begin
        chk("m_out_valid", out_valid, 1);
        chk("m_out_a",     out_a,   q[0].a);
        chk("m_out_b",     out_b,   q[0].b);
        chk("m_out_err",   out_err, q[0].err);
      end else begin
        chk("m_out_valid", out_valid, 0);
        chk("m_out_zero",  {out_a, out_b, out_err}, 0);
      end
      chk("m_in_ready",    in_ready,     q.size() < DEPTH);
      chk("m_err_count",   err_count,    m_cnt);
      chk("m_err_sticky",  err_sticky,   m_sticky);
      chk("m_sat_count",   s_err_count,  m_cnt_sat);
      chk("m_sat_sticky",  s_err_sticky, m_sticky);
      chk("m_sat_valid",   s_out_valid,  q.size() > 0);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change just after a falling edge.
  // --------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  // bad_bits flips bitwise-OR bits, bad_log flips the logical OR.
  task automatic set_word(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] bad_bits, input logic bad_log);
    in_not        = {~b, ~a};
    in_or_bitwise = (a | b) ^ bad_bits;
    in_or_logical = (|(a | b)) ^ bad_log;
  endtask

  logic [W-1:0] tab_a   [8] = '{3'd0, 3'd0, 3'd7, 3'd4, 3'd1, 3'd6, 3'd2, 3'd3};
  logic [W-1:0] tab_b   [8] = '{3'd0, 3'd0, 3'd7, 3'd0, 3'd2, 3'd1, 3'd2, 3'd4};
  logic [W-1:0] tab_bad [8] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
  logic         tab_log [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic         tab_rdy [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    reset = 1; in_valid = 0; out_ready = 0; clr_err = 0;
    in_not = '0; in_or_bitwise = '0; in_or_logical = 0;
    step(); step();
    reset = 0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_in_ready",  in_ready,  1);

    // Clean decode: a=101, b=001
    in_valid = 1; out_ready = 1;
    in_not = 6'b110010; in_or_bitwise = 3'b101; in_or_logical = 1;
    step();
    in_valid = 0;
    chk("clean_valid", out_valid, 1);
    chk("clean_a",     out_a,   3'b101);
    chk("clean_b",     out_b,   3'b001);
    chk("clean_err",   out_err, 0);
    chk("clean_cnt",   err_count, 0);
    step();
    chk("clean_drain", out_valid, 0);

    // Mismatch: same word with bitwise OR 111
    in_valid = 1;
    in_not = 6'b110010; in_or_bitwise = 3'b111; in_or_logical = 1;
    step();
    in_valid = 0;
    chk("mis_err",    out_err,    1);
    chk("mis_cnt",    err_count,  1);
    chk("mis_sticky", err_sticky, 1);
    step();

    // Backpressure: three words, depth two
    out_ready = 0; in_valid = 1;
    set_word(3'd1, 3'd2, 3'd0, 0);
    step();
    set_word(3'd3, 3'd4, 3'd0, 0);
    step();
    chk("bp_full_ready", in_ready, 0);
    chk("bp_head_w1",    out_a, 3'd1);
    set_word(3'd5, 3'd6, 3'd0, 0);
    step();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_w1",    out_a, 3'd1);
    chk("bp_hold_b1",    out_b, 3'd2);
    out_ready = 1;
    step();
    chk("bp_head_w2",    out_a, 3'd3);
    step();
    in_valid = 0;
    chk("bp_head_w3",    out_a, 3'd5);
    chk("bp_head_b3",    out_b, 3'd6);
    step();
    chk("bp_empty",      out_valid, 0);

    // Saturation on the CNT_W=2 instance
    clr_err = 1;
    step();
    clr_err = 0;
    chk("clr_cnt",    err_count,  0);
    chk("clr_sticky", err_sticky, 0);
    in_valid = 1;
    set_word(3'd2, 3'd5, 3'd1, 0);
    step(); chk("sat_1", s_err_count, 1);
    step(); chk("sat_2", s_err_count, 2);
    step(); chk("sat_3", s_err_count, 3);
    step(); chk("sat_4", s_err_count, 3);
    step(); chk("sat_5", s_err_count, 3);
    chk("sat_sticky", s_err_sticky, 1);
    chk("sat_main",   err_count,    5);

    // Clear colliding with an erroneous accept
    clr_err = 1;
    step();
    clr_err = 0; in_valid = 0;
    chk("coll_sat_cnt",  s_err_count, 1);
    chk("coll_cnt",      err_count,   1);
    chk("coll_sticky",   err_sticky,  1);
    step();

    // Reset mid-operation with two stored erroneous entries
    clr_err = 1;
    step();
    clr_err = 0; out_ready = 0; in_valid = 1;
    set_word(3'd7, 3'd1, 3'd4, 0);
    step();
    set_word(3'd0, 3'd3, 3'd0, 1);
    step();
    chk("pre_rst_cnt",   err_count, 2);
    chk("pre_rst_ready", in_ready,  0);
    reset = 1; clr_err = 1; out_ready = 1;
    set_word(3'd6, 3'd0, 3'd0, 0);
    step();
    reset = 0; clr_err = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt",   err_count, 0);
    chk("mid_rst_ready", in_ready,  1);
    step();
    in_valid = 0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_a",     out_a,     3'd6);
    step();

    // Directed mix, checked by the model only
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1;
      out_ready = tab_rdy[i];
      set_word(tab_a[i], tab_b[i], tab_bad[i], tab_log[i]);
      step();
    end
    in_valid = 0; out_ready = 1;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
